// File: rtl/staged_core_matrix_ctrl.sv
// Weight staging and run sequencer for the coupled-oscillator array. Writes land in a
// shadow store, and a commit copies the shadow store into the active copy that drives the fabric.
module staged_core_matrix_ctrl #(
    parameter int          N                = 8,
    parameter int          NUM_WEIGHTS      = 5,
    parameter int          WBITS            = $clog2(NUM_WEIGHTS),
    parameter logic [7:0]  WEIGHT_ADDR_MASK = 8'h01,
    parameter logic [7:0]  CTRL_ADDR_MASK   = 8'h02,
    parameter int          RST_CYCLES       = 4,
    parameter logic [31:0] DEFAULT_RUN      = 32'd1024
) (
    input  logic                           clk,
    input  logic                           axi_rst,
    input  logic                           wready,
    input  logic [31:0]                    wr_addr,
    input  logic [31:0]                    wdata,
    input  logic [31:0]                    rd_addr,
    output logic [31:0]                    rdata,
    input  logic [N-1:0]                   osc_in,
    output logic                           ising_rstn,
    output logic [N*(N-1)/2*WBITS-1:0]     weights,
    output logic                           busy,
    output logic                           done
);

    localparam int                NP         = N * (N - 1) / 2;
    localparam int                IDXW       = (NP > 1) ? $clog2(NP) : 1;
    localparam logic [10:0]       N_L        = 11'(N);
    localparam logic [WBITS-1:0]  W_MAX      = WBITS'(NUM_WEIGHTS - 1);
    localparam logic [WBITS-1:0]  W_ZERO     = WBITS'(NUM_WEIGHTS / 2);
    localparam logic [31:0]       RD_DEFAULT = 32'hAAAA_AAAA;
    localparam logic [31:0]       HOLD_LOAD  = 32'(RST_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RST_HOLD, RUN, SAMPLE} state_t;

    // Upper-triangle packing: row lo starts after the (N-1)+(N-2)+... entries of earlier rows.
    function automatic logic [IDXW-1:0] pair_idx(input logic [10:0] a, input logic [10:0] b);
        logic [10:0] lo;
        logic [10:0] hi;
        logic [31:0] t;
        lo = (a < b) ? a : b;
        hi = (a < b) ? b : a;
        t  = (32'(lo) * (32'(2 * N - 1) - 32'(lo))) / 32'd2 + 32'(hi) - 32'(lo) - 32'd1;
        return IDXW'(t);
    endfunction

    function automatic logic pair_ok(input logic [10:0] a, input logic [10:0] b);
        return (a != b) && (a < N_L) && (b < N_L);
    endfunction

    logic [WBITS-1:0] shadow_q [NP];
    logic [WBITS-1:0] active_q [NP];

    state_t           state_q, state_d;
    logic [31:0]      cnt_q, cnt_d;
    logic [31:0]      run_cycles_q;
    logic             done_q, done_d;
    logic             pending_q, pending_d;
    logic             rstn_q, rstn_d;
    logic [N-1:0]     snapshot_q, snapshot_d;
    logic [N-1:0]     osc_meta_q, osc_sync_q;
    logic [31:0]      rdata_q, rdata_d;
    logic             commit_now;

    // Write-side decode
    logic             wr_weight, wr_ctrl, wr_pair_ok;
    logic             commit_req, start_req, rc_write;
    logic [10:0]      wr_s, wr_d;
    logic [IDXW-1:0]  wr_idx;
    logic [WBITS-1:0] wr_val;

    assign wr_weight  = wready && (wr_addr[31:24] == WEIGHT_ADDR_MASK);
    assign wr_ctrl    = wready && (wr_addr[31:24] == CTRL_ADDR_MASK);
    assign wr_s       = wr_addr[12:2];
    assign wr_d       = wr_addr[23:13];
    assign wr_pair_ok = wr_weight && pair_ok(wr_s, wr_d);
    assign wr_idx     = pair_idx(wr_s, wr_d);
    assign wr_val     = (wdata[WBITS-1:0] > W_MAX) ? W_MAX : wdata[WBITS-1:0];
    assign commit_req = wr_ctrl && (wr_addr[7:2] == 6'd0) && wdata[0];
    assign start_req  = wr_ctrl && (wr_addr[7:2] == 6'd0) && wdata[1];
    assign rc_write   = wr_ctrl && (wr_addr[7:2] == 6'd2);

    // A write cycle also drives the read decode, so reads share the write address.
    logic [31:0]      rd_eff;
    logic [10:0]      rd_s, rd_d;
    logic [IDXW-1:0]  rd_idx;
    logic             unused_addr_lsbs;

    assign rd_eff           = wready ? wr_addr : rd_addr;
    assign rd_s             = rd_eff[12:2];
    assign rd_d             = rd_eff[23:13];
    assign rd_idx           = pair_idx(rd_s, rd_d);
    assign unused_addr_lsbs = ^rd_eff[1:0];

    always_comb begin
        rdata_d = RD_DEFAULT;
        if (rd_eff[31:24] == WEIGHT_ADDR_MASK) begin
            if (pair_ok(rd_s, rd_d)) begin
                rdata_d = 32'(shadow_q[rd_idx]);
            end
        end else if (rd_eff[31:24] == CTRL_ADDR_MASK) begin
            case (rd_eff[7:2])
                6'd1:    rdata_d = {29'b0, pending_q, done_q, busy};
                6'd2:    rdata_d = run_cycles_q;
                6'd3:    rdata_d = 32'(snapshot_q);
                default: rdata_d = RD_DEFAULT;
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        pending_d  = pending_q;
        snapshot_d = snapshot_q;
        commit_now = 1'b0;
        case (state_q)
            IDLE: begin
                // Commit precedes start, so a combined COMMIT+START runs on the new weights.
                if (commit_req || pending_q) begin
                    commit_now = 1'b1;
                    pending_d  = 1'b0;
                end
                if (start_req) begin
                    state_d = RST_HOLD;
                    done_d  = 1'b0;
                    cnt_d   = HOLD_LOAD;
                end
            end
            RST_HOLD: begin
                if (cnt_q == 32'd0) begin
                    state_d = RUN;
                    cnt_d   = (run_cycles_q == 32'd0) ? 32'd0 : run_cycles_q - 32'd1;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            RUN: begin
                if (cnt_q == 32'd0) begin
                    state_d = SAMPLE;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            SAMPLE: begin
                snapshot_d = osc_sync_q;
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if ((state_q != IDLE) && commit_req) begin
            pending_d = 1'b1;
        end
        rstn_d = (state_d == RUN) || (state_d == SAMPLE);
    end

    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state_q      <= IDLE;
            cnt_q        <= 32'd0;
            run_cycles_q <= DEFAULT_RUN;
            done_q       <= 1'b0;
            pending_q    <= 1'b0;
            rstn_q       <= 1'b0;
            snapshot_q   <= '0;
            osc_meta_q   <= '0;
            osc_sync_q   <= '0;
            rdata_q      <= RD_DEFAULT;
            for (int i = 0; i < NP; i++) begin
                shadow_q[i] <= W_ZERO;
                active_q[i] <= W_ZERO;
            end
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            pending_q  <= pending_d;
            rstn_q     <= rstn_d;
            snapshot_q <= snapshot_d;
            osc_meta_q <= osc_in;
            osc_sync_q <= osc_meta_q;
            rdata_q    <= rdata_d;
            if (rc_write) begin
                run_cycles_q <= wdata;
            end
            if (commit_now) begin
                active_q <= shadow_q;
            end
            if (wr_pair_ok) begin
                shadow_q[wr_idx] <= wr_val;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NP; gi++) begin : g_weights
            assign weights[gi*WBITS +: WBITS] = active_q[gi];
        end
    endgenerate

    assign rdata      = rdata_q;
    assign ising_rstn = rstn_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;

endmodule

// File: tb/tb_staged_core_matrix_ctrl.sv
// Randomized bench for staged_core_matrix_ctrl. It uses a symmetric-matrix weight model
// and a timeline model of each run.
module tb_staged_core_matrix_ctrl;

    localparam int N    = 8;
    localparam int NW   = 5;
    localparam int WB   = 3;
    localparam int RSTC = 4;
    localparam int NP   = N * (N - 1) / 2;
    localparam logic [31:0] AA = 32'hAAAAAAAA;

    logic              clk = 1'b0;
    logic              axi_rst = 1'b1;
    logic              wready = 1'b0;
    logic [31:0]       wr_addr = 32'd0;
    logic [31:0]       wdata = 32'd0;
    logic [31:0]       rd_addr = 32'd0;
    logic [31:0]       rdata;
    logic [N-1:0]      osc_in = '0;
    logic              ising_rstn, busy, done;
    logic [NP*WB-1:0]  weights;

    staged_core_matrix_ctrl #(
        .N(N), .NUM_WEIGHTS(NW), .WBITS(WB),
        .WEIGHT_ADDR_MASK(8'h01), .CTRL_ADDR_MASK(8'h02),
        .RST_CYCLES(RSTC), .DEFAULT_RUN(32'd1024)
    ) dut (
        .clk(clk), .axi_rst(axi_rst), .wready(wready), .wr_addr(wr_addr),
        .wdata(wdata), .rd_addr(rd_addr), .rdata(rdata), .osc_in(osc_in),
        .ising_rstn(ising_rstn), .weights(weights), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Model state: symmetric matrices, register values and a run timeline.
    int           sh_m [N][N];
    int           ac_m [N][N];
    logic [31:0]  rc_m;
    logic [N-1:0] snap_m;
    bit           done_m, pend_m, run_m;
    int           e_m, len_m;
    logic [31:0]  rdata_m;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] waddr(input int s, input int d);
        return {8'h01, 11'(d), 11'(s), 2'b00};
    endfunction

    function automatic logic [31:0] caddr(input int off);
        return {8'h02, 16'h0000, 6'(off), 2'b00};
    endfunction

    function automatic logic [NP*WB-1:0] pack_active();
        logic [NP*WB-1:0] v;
        int k;
        v = '0;
        k = 0;
        for (int lo = 0; lo < N; lo++) begin
            for (int hi = lo + 1; hi < N; hi++) begin
                v[k*WB +: WB] = 3'(ac_m[lo][hi]);
                k++;
            end
        end
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        int s, d;
        if (a[31:24] == 8'h01) begin
            s = int'(a[12:2]);
            d = int'(a[23:13]);
            if (s != d && s < N && d < N) return 32'(sh_m[s][d]);
            return AA;
        end
        if (a[31:24] == 8'h02) begin
            case (int'(a[7:2]))
                1: return {29'b0, pend_m, done_m, run_m};
                2: return rc_m;
                3: return 32'(snap_m);
                default: return AA;
            endcase
        end
        return AA;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                sh_m[i][j] = NW / 2;
                ac_m[i][j] = NW / 2;
            end
        end
        rc_m = 32'd1024; snap_m = '0; done_m = 0; pend_m = 0; run_m = 0;
        e_m = 0; len_m = 0; rdata_m = AA;
    endtask

    task automatic model_edge();
        logic [31:0] ea;
        int s, d, v;
        bit com, st;
        ea = wready ? wr_addr : rd_addr;
        rdata_m = exp_read(ea);
        com = 0; st = 0;
        if (wready && wr_addr[31:24] == 8'h02 && wr_addr[7:2] == 6'd0) begin
            com = wdata[0];
            st  = wdata[1];
        end
        if (run_m) begin
            if (com) pend_m = 1;
            if (e_m == RSTC + len_m) begin
                snap_m = osc_in; done_m = 1; run_m = 0;
            end else begin
                if (e_m == RSTC - 1) len_m = (rc_m == 0) ? 1 : int'(rc_m);
                e_m++;
            end
        end else begin
            if (com || pend_m) begin
                ac_m = sh_m;
                pend_m = 0;
            end
            if (st) begin
                run_m = 1; e_m = 0; done_m = 0;
            end
        end
        if (wready && wr_addr[31:24] == 8'h01) begin
            s = int'(wr_addr[12:2]);
            d = int'(wr_addr[23:13]);
            if (s != d && s < N && d < N) begin
                v = int'(wdata[2:0]);
                if (v > NW - 1) v = NW - 1;
                sh_m[s][d] = v;
                sh_m[d][s] = v;
            end
        end
        if (wready && wr_addr[31:24] == 8'h02 && wr_addr[7:2] == 6'd2) rc_m = wdata;
    endtask

    task automatic compare_all();
        check("rdata", rdata, rdata_m);
        check("busy", busy, run_m);
        check("ising_rstn", ising_rstn, run_m && (e_m >= RSTC));
        check("done", done, done_m);
        check("weights", weights, pack_active());
    endtask

    task automatic step(input logic we, input logic [31:0] wa, input logic [31:0] wd,
                        input logic [31:0] ra);
        wready = we; wr_addr = wa; wdata = wd; rd_addr = ra;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        axi_rst = 1'b1; wready = 1'b0;
        @(posedge clk);
        model_reset();
        #1;
        compare_all();
        axi_rst = 1'b0;
    endtask

    logic [NP*WB-1:0] all_two;
    int lo_cnt, hi_cnt;
    int r;
    logic [31:0] wd;

    initial begin
        for (int k = 0; k < NP; k++) all_two[k*WB +: WB] = 3'd2;

        // Reset state
        do_reset();
        do_reset();
        check("reset_weights", weights, all_two);
        check("reset_rstn", ising_rstn, 1'b0);
        step(0, 0, 0, waddr(1, 3));
        check("rd_w13_reset", rdata, 32'h2);
        step(0, 0, 0, caddr(1));
        check("status_reset", rdata, 32'h0);

        // Shadow write, symmetric read, commit, saturation, diagonal ignore
        step(1, waddr(2, 5), 32'd4, 0);
        step(0, 0, 0, waddr(5, 2));
        check("rd_w52", rdata, 32'h4);
        check("active_pre_commit", weights[15*WB +: WB], 3'd2);
        step(1, caddr(0), 32'd1, 0);
        check("active_post_commit", weights[15*WB +: WB], 3'd4);
        step(1, waddr(2, 5), 32'd7, 0);
        step(0, 0, 0, waddr(2, 5));
        check("rd_saturated", rdata, 32'h4);
        step(1, waddr(3, 3), 32'd1, 0);
        step(0, 0, 0, waddr(3, 3));
        check("rd_diag", rdata, AA);

        // Run with RUN_CYCLES=10 and a stable spin pattern
        step(1, caddr(2), 32'd10, 0);
        osc_in = 8'hA5;
        lo_cnt = 0; hi_cnt = 0;
        for (int i = 0; i < 21; i++) begin
            if (i == 0) step(1, caddr(0), 32'd2, 0);
            else step(0, 0, 0, caddr(1));
            if (busy && !ising_rstn) lo_cnt++;
            if (ising_rstn) hi_cnt++;
        end
        check("rst_low_cycles", lo_cnt, 4);
        check("rstn_high_cycles", hi_cnt, 11);
        check("done_after_run", done, 1'b1);
        step(0, 0, 0, caddr(3));
        check("snapshot_a5", rdata, 32'hA5);

        // COMMIT and START while running
        step(1, waddr(0, 1), 32'd0, 0);
        step(1, caddr(0), 32'd2, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        step(1, caddr(0), 32'd1, 0);
        step(0, 0, 0, caddr(1));
        check("status_pending", rdata, 32'h5);
        check("active_held_busy", weights[0 +: WB], 3'd2);
        step(1, caddr(0), 32'd2, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check("active_after_idle", weights[0 +: WB], 3'd0);
        step(0, 0, 0, caddr(1));
        check("status_idle", rdata, 32'h2);

        // RUN_CYCLES=0 with combined COMMIT+START
        step(1, caddr(2), 32'd0, 0);
        step(1, waddr(0, 7), 32'd1, 0);
        osc_in = 8'h3C;
        lo_cnt = 0; hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0) step(1, caddr(0), 32'd3, 0);
            else step(0, 0, 0, 0);
            if (i == 0) check("commit_start_weight", weights[6*WB +: WB], 3'd1);
            if (busy && !ising_rstn) lo_cnt++;
            if (ising_rstn) hi_cnt++;
        end
        check("rc0_low_cycles", lo_cnt, 4);
        check("rc0_high_cycles", hi_cnt, 2);

        // Reset in the middle of a run
        step(1, caddr(2), 32'd50, 0);
        step(1, caddr(0), 32'd2, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        do_reset();
        check("midrst_busy", busy, 1'b0);
        check("midrst_rstn", ising_rstn, 1'b0);
        check("midrst_weights", weights, all_two);
        check("midrst_done", done, 1'b0);
        step(0, 0, 0, caddr(3));
        check("midrst_snapshot", rdata, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                step(1, waddr($urandom_range(0, N + 1), $urandom_range(0, N + 1)),
                     32'($urandom_range(0, 7)), $urandom);
            end else if (r < 50) begin
                wd = 32'($urandom_range(0, 3));
                if (wd[1] && !run_m) osc_in = N'($urandom);
                step(1, caddr(0), wd, 0);
            end else if (r < 55) begin
                step(1, caddr(2), 32'($urandom_range(0, 12)), 0);
            end else if (r < 58) begin
                step(1, caddr($urandom_range(4, 63)), $urandom, 0);
            end else if (r < 59) begin
                do_reset();
            end else if (r < 80) begin
                step(0, $urandom, $urandom,
                     waddr($urandom_range(0, N + 1), $urandom_range(0, N + 1)));
            end else if (r < 95) begin
                step(0, 0, 0, caddr($urandom_range(0, 5)));
            end else begin
                step(0, 0, 0, $urandom);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
